// File: rtl/flag_pkg.sv
// Shared flag-file definitions: condition codes, default flag indices,
// and the 3-bit flag vector type used by branch and ALU logic.
package flag_pkg;

    localparam logic [2:0] CC_NEQ = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GTE = 3'b100;
    localparam logic [2:0] CC_LTE = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    localparam int Z_IDX_DEF = 2;
    localparam int V_IDX_DEF = 1;
    localparam int N_IDX_DEF = 0;

    typedef logic [2:0] flags3_t;

    function automatic flags3_t pack_zvn(input logic z, input logic v, input logic n);
        flags3_t f;
        f            = '0;
        f[Z_IDX_DEF] = z;
        f[V_IDX_DEF] = v;
        f[N_IDX_DEF] = n;
        return f;
    endfunction

endpackage

// File: rtl/dff.sv
// Single flag storage cell: synchronous active-high reset, load on wen.
// Reset takes priority over any load.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic wen,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/flag_file_pipe_cond_eval.sv
// Combinational branch-condition evaluator on Z/V/N.
// Shared between the flag file and the branch unit.
module flag_cond_eval
    import flag_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       z,
    input  logic       v,
    input  logic       n,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        unique case (ccc)
            CC_NEQ: cond_true = ~z;
            CC_EQ:  cond_true = z;
            CC_GT:  cond_true = ~z & ~n;
            CC_LT:  cond_true = n;
            CC_GTE: cond_true = z | (~z & ~n);
            CC_LTE: cond_true = n | z;
            CC_OV:  cond_true = v;
            CC_UNC: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_file_pipe.sv
// Pipelined condition-flag file with bypass, stall/flush squash and change pulse.
// Optional FLAG_SHADOW_EN adds a save/restore shadow for trap entry/exit.
module flag_file_pipe
    import flag_pkg::*;
#(
    parameter int NFLAGS = 3,
    parameter int Z_IDX  = Z_IDX_DEF,
    parameter int V_IDX  = V_IDX_DEF,
    parameter int N_IDX  = N_IDX_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NFLAGS-1:0] wen,
    input  logic [NFLAGS-1:0] flags_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        ccc,
`ifdef FLAG_SHADOW_EN
    input  logic              save,
    input  logic              restore,
`endif
    output logic [NFLAGS-1:0] flags_out,
    output logic [NFLAGS-1:0] flags_eff,
    output logic              cond_true,
    output logic              flags_chg
);

    logic [NFLAGS-1:0] qwen;
    logic [NFLAGS-1:0] flags_q;
    logic [NFLAGS-1:0] wr_en;
    logic [NFLAGS-1:0] wr_val;

    assign qwen = wen & {NFLAGS{~stall & ~flush}};

`ifdef FLAG_SHADOW_EN
    logic [NFLAGS-1:0] shadow;

    // Shadow captures the pre-update value; restore wins over save.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (save && !restore) begin
            shadow <= flags_q;
        end
    end

    assign wr_en  = restore ? {NFLAGS{1'b1}} : qwen;
    assign wr_val = restore ? shadow : flags_in;
`else
    assign wr_en  = qwen;
    assign wr_val = flags_in;
`endif

    for (genvar i = 0; i < NFLAGS; i++) begin : g_bit
        dff u_dff (
            .clk (clk),
            .rst (rst),
            .wen (wr_en[i]),
            .d   (wr_val[i]),
            .q   (flags_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_chg <= 1'b0;
        end else begin
            flags_chg <= |(wr_en & (wr_val ^ flags_q));
        end
    end

    assign flags_out = flags_q;

    if (BYPASS != 0) begin : g_byp
        assign flags_eff = (wr_en & wr_val) | (~wr_en & flags_q);
    end else begin : g_nobyp
        assign flags_eff = flags_q;
    end

    flag_cond_eval u_cond (
        .ccc       (ccc),
        .z         (flags_eff[Z_IDX]),
        .v         (flags_eff[V_IDX]),
        .n         (flags_eff[N_IDX]),
        .cond_true (cond_true)
    );

endmodule

// File: tb/tb_flag_file_pipe.sv
// Directed self-checking bench for flag_file_pipe (BYPASS=1 and BYPASS=0).
// Shadow save/restore steps are built only with FLAG_SHADOW_EN.
module tb_flag_file_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] wen;
    logic [2:0] flags_in;
    logic       stall;
    logic       flush;
    logic [2:0] ccc;
    logic [2:0] flags_out, flags_eff;
    logic       cond_true, flags_chg;
    logic [2:0] flags_out0, flags_eff0;
    logic       cond_true0, flags_chg0;
`ifdef FLAG_SHADOW_EN
    logic       save;
    logic       restore;
`endif

    int checks = 0;
    int errors = 0;

    // Expected cond_true per ccc, bit index = {Z,V,N}
    logic [7:0] tbl [8];

    always #5 clk = ~clk;

    flag_file_pipe #(.NFLAGS(3), .BYPASS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .flags_in  (flags_in),
        .stall     (stall),
        .flush     (flush),
        .ccc       (ccc),
`ifdef FLAG_SHADOW_EN
        .save      (save),
        .restore   (restore),
`endif
        .flags_out (flags_out),
        .flags_eff (flags_eff),
        .cond_true (cond_true),
        .flags_chg (flags_chg)
    );

    flag_file_pipe #(.NFLAGS(3), .BYPASS(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .flags_in  (flags_in),
        .stall     (stall),
        .flush     (flush),
        .ccc       (ccc),
`ifdef FLAG_SHADOW_EN
        .save      (save),
        .restore   (restore),
`endif
        .flags_out (flags_out0),
        .flags_eff (flags_eff0),
        .cond_true (cond_true0),
        .flags_chg (flags_chg0)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] w, input logic [2:0] v);
        wen      = w;
        flags_in = v;
        tick();
        wen      = 3'b000;
    endtask

    initial begin
        tbl[0] = 8'h0F;
        tbl[1] = 8'hF0;
        tbl[2] = 8'h05;
        tbl[3] = 8'hAA;
        tbl[4] = 8'hF5;
        tbl[5] = 8'hFA;
        tbl[6] = 8'hCC;
        tbl[7] = 8'hFF;

        rst = 1'b1; wen = 3'b000; flags_in = 3'b000;
        stall = 1'b0; flush = 1'b0; ccc = 3'b000;
`ifdef FLAG_SHADOW_EN
        save = 1'b0; restore = 1'b0;
`endif
        // Reset
        tick();
        tick();
        check("rst_out", {5'd0, flags_out}, 8'h00);
        check("rst_chg", {7'd0, flags_chg}, 8'h00);
        ccc = 3'b000; #1;
        check("rst_ccc000", {7'd0, cond_true}, 8'h01);
        ccc = 3'b001; #1;
        check("rst_ccc001", {7'd0, cond_true}, 8'h00);
        rst = 1'b0;

        // Full write with same-cycle bypass
        wen = 3'b111; flags_in = 3'b100; ccc = 3'b001; #1;
        check("byp_eff", {5'd0, flags_eff}, 8'h04);
        check("byp_cond_eq", {7'd0, cond_true}, 8'h01);
        check("nobyp_eff", {5'd0, flags_eff0}, 8'h00);
        check("nobyp_cond", {7'd0, cond_true0}, 8'h00);
        tick();
        wen = 3'b000;
        check("full_out", {5'd0, flags_out}, 8'h04);
        check("full_chg", {7'd0, flags_chg}, 8'h01);
        tick();
        check("hold_out", {5'd0, flags_out}, 8'h04);
        check("hold_chg", {7'd0, flags_chg}, 8'h00);

        // Partial write touches Z only
        write(3'b111, 3'b111);
        write(3'b100, 3'b000);
        check("part_out", {5'd0, flags_out}, 8'h03);
        check("part_chg", {7'd0, flags_chg}, 8'h01);
        ccc = 3'b011; #1;
        check("part_lt", {7'd0, cond_true}, 8'h01);
        ccc = 3'b110; #1;
        check("part_ov", {7'd0, cond_true}, 8'h01);
        ccc = 3'b001; #1;
        check("part_eq", {7'd0, cond_true}, 8'h00);

        // Stall, flush, and both together suppress the write
        for (int k = 1; k <= 3; k++) begin
            stall = k[0]; flush = k[1];
            wen = 3'b111; flags_in = 3'b010; #1;
            check("sq_eff", {5'd0, flags_eff}, 8'h03);
            tick();
            check("sq_out", {5'd0, flags_out}, 8'h03);
            check("sq_chg", {7'd0, flags_chg}, 8'h00);
        end
        stall = 1'b0; flush = 1'b0; wen = 3'b000;

        // Redundant rewrite
        write(3'b111, 3'b001);
        check("red_first_chg", {7'd0, flags_chg}, 8'h01);
        write(3'b111, 3'b001);
        check("red_out", {5'd0, flags_out}, 8'h01);
        check("red_chg", {7'd0, flags_chg}, 8'h00);

        // Reset during stall
        write(3'b111, 3'b110);
        rst = 1'b1; stall = 1'b1; wen = 3'b111; flags_in = 3'b111;
        tick();
        check("rst_stall_out", {5'd0, flags_out}, 8'h00);
        check("rst_stall_chg", {7'd0, flags_chg}, 8'h00);
        rst = 1'b0; stall = 1'b0; wen = 3'b000;

        // Condition sweep over committed flags
        for (int f = 0; f < 8; f++) begin
            write(3'b111, f[2:0]);
            for (int c = 0; c < 8; c++) begin
                ccc = c[2:0]; #1;
                check($sformatf("sweep_f%0d_c%0d", f, c),
                      {7'd0, cond_true}, {7'd0, tbl[c][f]});
            end
        end

`ifdef FLAG_SHADOW_EN
        write(3'b111, 3'b101);
        save = 1'b1;
        tick();
        save = 1'b0;
        write(3'b111, 3'b010);
        restore = 1'b1; wen = 3'b111; flags_in = 3'b111; #1;
        check("rest_eff", {5'd0, flags_eff}, 8'h05);
        tick();
        restore = 1'b0; wen = 3'b000;
        check("rest_out", {5'd0, flags_out}, 8'h05);
        check("rest_chg", {7'd0, flags_chg}, 8'h01);
        write(3'b111, 3'b011);
        save = 1'b1; restore = 1'b1;
        tick();
        save = 1'b0; restore = 1'b0;
        check("sr_out", {5'd0, flags_out}, 8'h05);
        write(3'b111, 3'b000);
        restore = 1'b1;
        tick();
        restore = 1'b0;
        check("sr_shadow_kept", {5'd0, flags_out}, 8'h05);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
